fft_frame_buffer: RTL and testbench

- Upstream stage of the audio FFT. Collects 12-bit unsigned PmodAD1 samples into frames of N = 2^N_LOG2 samples.
- Converts each sample to 13-bit signed Q1.12, the format the butterfly/FFT stages consume.
- Ping-pong buffered: one frame fills while the previous frame streams out in bit-reversed order, ready for an in-place radix-2 DIT FFT.

---
 rtl/fft_pkg.sv | 34 +++
 rtl/fft_frame_buffer_hann_rom.sv | 22 ++
 rtl/fft_frame_buffer.sv | 147 ++++++++++++++
 tb/tb_fft_frame_buffer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, sample type and helpers for the FFT front end.
// hann_coef is used only when FFT_FRAME_WINDOW_EN is defined.
package fft_pkg;

  localparam int ADC_W      = 12;
  localparam int DATA_W     = 13;
  localparam int ADC_OFFSET = 2048;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Offset-binary ADC code to Q1.12: remove mid-scale, then scale by two.
  function automatic sample_t to_q112(input logic [ADC_W-1:0] code);
    sample_t d;
    d = $signed({1'b0, code}) - sample_t'(ADC_OFFSET);
    return d <<< 1;
  endfunction

  // Reverses the low `width` bits of value; width is 1..10.
  function automatic logic [9:0] bitrev(input logic [9:0] value, input int width);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++)
      if (i < width) r[i] = value[width-1-i];
    return r;
  endfunction

  // Hann coefficient, 4096 = 1.0; evaluated at elaboration time only.
  function automatic logic [DATA_W-1:0] hann_coef(input int n, input int n_log2);
    real ph;
    ph = 2.0 * 3.14159265358979 * n / (1 << n_log2);
    return DATA_W'($rtoi(2048.0 * (1.0 - $cos(ph)) + 0.5));
  endfunction

endpackage

// File: rtl/fft_frame_buffer_hann_rom.sv
// Combinational Hann window ROM indexed by natural-order sample index.
// Instantiated only when FFT_FRAME_WINDOW_EN is defined.
module hann_rom
  import fft_pkg::*;
#(
  parameter int N_LOG2 = 2
) (
  input  logic [N_LOG2-1:0] idx,
  output logic [DATA_W-1:0] coef
);

  localparam int N = 1 << N_LOG2;

  logic [DATA_W-1:0] rom [N];

  for (genvar g = 0; g < N; g++) begin : g_rom
    assign rom[g] = hann_coef(g, N_LOG2);
  end

  assign coef = rom[idx];

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer: fills one bank in natural order while the other
// streams out bit-reversed. Define FFT_FRAME_WINDOW_EN to apply a Hann window.
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int N_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [ADC_W-1:0]         in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic [N_LOG2-1:0]        out_index,
  output logic                     out_last,
  output logic                     overrun
);

  localparam int N = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST_IDX = '1;
  localparam logic [N_LOG2-1:0] ONE      = N_LOG2'(1);

  // READ: samples remain to be loaded; LAST: final sample held, awaiting transfer.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [N_LOG2-1:0] rd_cnt_q, rd_cnt_d;
  logic [N_LOG2-1:0] wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              overrun_q, overrun_d;
  logic              out_valid_q, out_valid_d;
  sample_t           out_data_q, out_data_d;
  logic [N_LOG2-1:0] out_index_q, out_index_d;
  logic              out_last_q, out_last_d;

  sample_t           buf_mem [2][N];
  logic [N_LOG2-1:0] rd_addr;
  sample_t           rd_word;
  sample_t           load_data;
  logic              xfer, load, frame_done, rd_free, swap;

  always_ff @(posedge clk)
    if (in_valid) buf_mem[wr_bank_q][wr_cnt_q] <= to_q112(in_data);

  // The read bank is always the one not being written.
  assign rd_addr = N_LOG2'(bitrev(10'(rd_cnt_q), N_LOG2));
  assign rd_word = buf_mem[~wr_bank_q][rd_addr];

`ifdef FFT_FRAME_WINDOW_EN
  logic [DATA_W-1:0]  coef;
  logic signed [26:0] prod;

  hann_rom #(.N_LOG2(N_LOG2)) u_hann_rom (
    .idx  (rd_addr),
    .coef (coef)
  );

  // Coefficient reaches 4096, so it is widened to stay positive as signed.
  assign prod      = rd_word * $signed({1'b0, coef});
  assign load_data = prod[24:12];
`else
  assign load_data = rd_word;
`endif

  assign xfer       = out_valid_q & out_ready;
  assign load       = (state_q == ST_READ) & (~out_valid_q | out_ready);
  assign frame_done = in_valid & (wr_cnt_q == LAST_IDX);
  assign rd_free    = (state_q == ST_IDLE) | ((state_q == ST_LAST) & xfer);
  assign swap       = frame_done & rd_free;

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    overrun_d   = overrun_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;

    if (in_valid) wr_cnt_d = wr_cnt_q + ONE;
    if (frame_done && !rd_free) overrun_d = 1'b1;

    case (state_q)
      ST_READ: begin
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = load_data;
          out_index_d = rd_addr;
          out_last_d  = (rd_cnt_q == LAST_IDX);
          rd_cnt_d    = rd_cnt_q + ONE;
          if (rd_cnt_q == LAST_IDX) state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: ;
    endcase

    // A swap on the final transfer edge keeps streaming without visiting IDLE.
    if (swap) begin
      state_d   = ST_READ;
      rd_cnt_d  = '0;
      wr_bank_d = ~wr_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      overrun_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer with N_LOG2=2; expected values are
// hand-computed Q1.12 samples, windowed when FFT_FRAME_WINDOW_EN is defined.
module tb_fft_frame_buffer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic [11:0]        in_data;
  logic               out_ready;
  logic               out_valid;
  logic signed [12:0] out_data;
  logic [1:0]         out_index;
  logic               out_last;
  logic               overrun;

  int checks   = 0;
  int failures = 0;

  fft_frame_buffer #(.N_LOG2(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected output for Q1.12 sample x at natural index idx (N=4 Hann table).
  function automatic int win(input int x, input int idx);
`ifdef FFT_FRAME_WINDOW_EN
    int w;
    case (idx)
      0:       w = 0;
      1:       w = 2048;
      2:       w = 4096;
      default: w = 2048;
    endcase
    return (x * w) >>> 12;
`else
    return x + 0 * idx;
`endif
  endfunction

  task automatic expect_out(input string tag, input int x, input int idx, input bit last);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"},  out_data,  win(x, idx));
    chk({tag, "_index"}, out_index, idx);
    chk({tag, "_last"},  out_last,  last);
  endtask

  task automatic send_frame(input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] c, input logic [11:0] d);
    logic [11:0] s [4];
    s = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int nxt_idx [3];
    int nxt_lst [3];
    nxt_idx = '{2, 1, 3};
    nxt_lst = '{0, 0, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid",   out_valid, 0);
    chk("rst_data",    out_data,  0);
    chk("rst_index",   out_index, 0);
    chk("rst_last",    out_last,  0);
    chk("rst_overrun", overrun,   0);
    rst_n = 1'b1;
    tick();

    // DC 0x900 -> 512 in every slot, bit-reversed order.
    send_frame(12'h900, 12'h900, 12'h900, 12'h900);
    chk("dc_swap_valid", out_valid, 0);
    tick(); expect_out("dc0", 512, 0, 0);
    tick(); expect_out("dc1", 512, 2, 0);
    tick(); expect_out("dc2", 512, 1, 0);
    tick(); expect_out("dc3", 512, 3, 1);
    tick(); chk("dc_end_valid", out_valid, 0);

    // Ramp covering both ends of the range.
    send_frame(12'd0, 12'd1024, 12'd2048, 12'd4095);
    tick(); expect_out("ramp0", -4096, 0, 0);
    tick(); expect_out("ramp1", 0,     2, 0);
    tick(); expect_out("ramp2", -2048, 1, 0);
    tick(); expect_out("ramp3", 4094,  3, 1);
    tick(); chk("ramp_end_valid", out_valid, 0);

    // Backpressure mid-frame: idx2 must hold for five stalled cycles.
    send_frame(12'd100, 12'd200, 12'd300, 12'd400);
    tick(); expect_out("bp0", -3896, 0, 0);
    tick(); expect_out("bp1", -3496, 2, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); expect_out("bp_hold", -3496, 2, 0);
    end
    out_ready = 1'b1;
    tick(); expect_out("bp2", -3696, 1, 0);
    tick(); expect_out("bp3", -3296, 3, 1);
    tick(); chk("bp_end_valid", out_valid, 0);
    chk("bp_overrun", overrun, 0);

    // Overrun: two frames arrive while the first is stalled.
    out_ready = 1'b0;
    send_frame(12'h100, 12'h200, 12'h300, 12'h400);
    send_frame(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
    send_frame(12'h000, 12'h000, 12'h000, 12'h000);
    tick();
    chk("ovr_flag", overrun, 1);
    expect_out("ovr_hold", -3584, 0, 0);
    out_ready = 1'b1;
    tick(); expect_out("ovr1", -2560, 2, 0);
    tick(); expect_out("ovr2", -3072, 1, 0);
    tick(); expect_out("ovr3", -2048, 3, 1);
    tick(); chk("ovr_end_valid", out_valid, 0);
    tick(); chk("ovr_no_drop_valid", out_valid, 0);
    chk("ovr_sticky", overrun, 1);

    // Reset during readout with a partial frame pending.
    send_frame(12'h880, 12'h880, 12'h880, 12'h880);
    tick(); expect_out("rr0", 256, 0, 0);
    in_valid = 1'b1;
    in_data  = 12'hFFF;
    tick(); expect_out("rr1", 256, 2, 0);
    tick(); expect_out("rr2", 256, 1, 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    chk("rr_valid",   out_valid, 0);
    chk("rr_overrun", overrun,   0);
    rst_n = 1'b1;
    send_frame(12'h7FF, 12'h801, 12'h000, 12'hC00);
    tick(); expect_out("fresh0", -2,    0, 0);
    tick(); expect_out("fresh1", -4096, 2, 0);
    tick(); expect_out("fresh2", 2,     1, 0);
    tick(); expect_out("fresh3", 2048,  3, 1);
    tick(); chk("fresh_end_valid", out_valid, 0);

    // Next frame completes on the same edge as the final transfer.
    send_frame(12'h900, 12'h900, 12'h900, 12'h900);
    tick(); expect_out("b2b_e0", 512, 0, 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 12'h700;
      tick();
      if (i < 3) expect_out("b2b_e", 512, nxt_idx[i], nxt_lst[i]);
      else       chk("b2b_gap_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    tick(); expect_out("b2b_f0", -512, 0, 0);
    tick(); expect_out("b2b_f1", -512, 2, 0);
    tick(); expect_out("b2b_f2", -512, 1, 0);
    tick(); expect_out("b2b_f3", -512, 3, 1);
    tick(); chk("b2b_end_valid", out_valid, 0);
    chk("b2b_overrun", overrun, 0);

`ifdef FFT_FRAME_WINDOW_EN
    send_frame(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
    tick(); chk("win0", out_data, 0);
    tick(); chk("win1", out_data, 4094);
    tick(); chk("win2", out_data, 2047);
    tick(); chk("win3", out_data, 2047);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
